// File: rtl/sim_end_sequencer.sv
// sim_end_sequencer: ends the run in a fixed order. It waits for the done
// flags or the cycle limit, then a monitor drain, then raises sim_end.
//
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   host32_is_active  - host model has started
//   use_done          - allow the done flags to end the run
//   if_done, pci_done - per-port ingress and PCI done flags
//   finish_cycles     - cycle limit, 0 means no limit
//   drain_ack         - monitor flush acks, top bit is the PCI monitor
//   drain_req         - ask the monitors to flush
//   sim_end           - run may end, sticky until reset
//   end_cause         - 01 done flags, 10 cycle limit, 00 not ended
//   drain_timeout     - drain ended by timeout rather than acks
//   cycle_count       - edges since reset release, saturating
module sim_end_sequencer #(
  parameter int NUM_PORTS     = 4,
  parameter int QUIET_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 host32_is_active,
  input  logic                 use_done,
  input  logic [NUM_PORTS-1:0] if_done,
  input  logic                 pci_done,
  input  logic [CNT_WIDTH-1:0] finish_cycles,
  input  logic [NUM_PORTS:0]   drain_ack,
  output logic                 drain_req,
  output logic                 sim_end,
  output logic [1:0]           end_cause,
  output logic                 drain_timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_DONE  = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_QUIET,
    S_DRAIN,
    S_END
  } state_t;

  state_t               r_state;
  logic [QW-1:0]        r_quiet_cnt;
  logic [DW-1:0]        r_drain_cnt;
  logic [NUM_PORTS:0]   r_ack_seen;
  logic                 r_drain_req;
  logic                 r_sim_end;
  logic [1:0]           r_end_cause;
  logic                 r_drain_timeout;
  logic [CNT_WIDTH-1:0] r_cycle_count;

  logic       w_limit_hit;
  logic       w_all_done;
  logic       w_ack_all;
  logic       w_pre_drain;
  logic       w_quiet_done;
  logic       w_go_drain;
  logic [1:0] w_cause;

  assign w_limit_hit = (finish_cycles != '0) &&
                       (r_cycle_count >= finish_cycles);
  assign w_all_done  = &{if_done, pci_done};
  assign w_ack_all   = &(r_ack_seen | drain_ack);

  // The limit is only honoured before the drain starts; once draining,
  // the cause is frozen and only acks or the timeout move us on.
  assign w_pre_drain  = (r_state == S_IDLE) ||
                        (r_state == S_RUN)  ||
                        (r_state == S_QUIET);
  assign w_quiet_done = (r_state == S_QUIET) && use_done &&
                        w_all_done && (r_quiet_cnt == QLAST);
  assign w_go_drain   = w_pre_drain && (w_limit_hit || w_quiet_done);
  assign w_cause      = w_limit_hit ? CAUSE_LIMIT : CAUSE_DONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_quiet_cnt     <= '0;
      r_drain_cnt     <= '0;
      r_ack_seen      <= '0;
      r_drain_req     <= 1'b0;
      r_sim_end       <= 1'b0;
      r_end_cause     <= 2'b00;
      r_drain_timeout <= 1'b0;
      r_cycle_count   <= '0;
    end else begin
      if (r_cycle_count != '1)
        r_cycle_count <= r_cycle_count + 1'b1;

      if (w_go_drain) begin
        r_state     <= S_DRAIN;
        r_drain_req <= 1'b1;
        r_ack_seen  <= '0;
        r_drain_cnt <= '0;
        r_end_cause <= w_cause;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (host32_is_active)
              r_state <= S_RUN;
          end
          S_RUN: begin
            if (use_done && w_all_done) begin
              r_state     <= S_QUIET;
              r_quiet_cnt <= '0;
            end
          end
          S_QUIET: begin
            if (!w_all_done || !use_done)
              r_state <= S_RUN;
            else
              r_quiet_cnt <= r_quiet_cnt + 1'b1;
          end
          S_DRAIN: begin
            if (w_ack_all) begin
              r_state     <= S_END;
              r_drain_req <= 1'b0;
              r_sim_end   <= 1'b1;
            end else if (r_drain_cnt == DLAST) begin
              r_state         <= S_END;
              r_drain_req     <= 1'b0;
              r_sim_end       <= 1'b1;
              r_drain_timeout <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
              r_ack_seen  <= r_ack_seen | drain_ack;
            end
          end
          S_END: begin
            r_state <= S_END;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign drain_req     = r_drain_req;
  assign sim_end       = r_sim_end;
  assign end_cause     = r_end_cause;
  assign drain_timeout = r_drain_timeout;
  assign cycle_count   = r_cycle_count;

endmodule
